rx_serial_a_paralelo: RTL and testbench



---
 rtl/rx_serial_a_paralelo_pkg.sv | 16 +
 rtl/rx_serial_a_paralelo_if.sv | 15 +
 rtl/rx_serial_a_paralelo_comma_detect.sv | 29 ++
 rtl/rx_serial_a_paralelo.sv | 145 ++++++++++++++
 tb/tb_rx_serial_a_paralelo.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/rx_serial_a_paralelo_pkg.sv
// Shared types and constants for the Rx serial-to-nibble front end.
// No logic: states, symbol/nibble widths and the default comma code.
package rx_pkg;

  localparam int SYM_W = 8;
  localparam int NIB_W = 4;

  localparam logic [SYM_W-1:0] COMMA_DEF = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH,
    COUNTING,
    LOCKED
  } rx_state_e;

endpackage

// File: rtl/rx_serial_a_paralelo_if.sv
// Serial line in, nibble stream plus link status out.
// slave = receiver side, master = line driver / nibble consumer side.
interface rx_serial_a_paralelo_if;
  import rx_pkg::*;

  logic             data_serial;
  logic [NIB_W-1:0] data_out;
  logic             valid_out;
  logic             nib_stb;
  logic             active;

  modport master (output data_serial, input data_out, valid_out, nib_stb, active);
  modport slave  (input data_serial, output data_out, valid_out, nib_stb, active);

endinterface

// File: rtl/rx_serial_a_paralelo_comma_detect.sv
// Serial shift register and comma compare over the current 8-bit window.
// Combinational sym/is_comma from the incoming bit; no backpressure.
module rx_comma_detect
  import rx_pkg::*;
#(
  parameter logic [SYM_W-1:0] COMMA = COMMA_DEF
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic             data_serial,
  output logic [SYM_W-1:0] sym,
  output logic             is_comma
);

  // Only the seven most recent bits are needed to form the window with the live bit.
  logic [SYM_W-2:0] sr;

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      sr <= '0;
    end else begin
      sr <= {sr[SYM_W-3:0], data_serial};
    end
  end

  assign sym      = {sr, data_serial};
  assign is_comma = (sym == COMMA);

endmodule

// File: rtl/rx_serial_a_paralelo.sv
// Comma alignment, lock FSM and 8->4 gearbox; nibbles every 4 clk_32f, high first,
// high nibble one edge after a symbol's last bit; no backpressure. Option: RX_LOSS_OF_SYNC_EN.
module rx_serial_a_paralelo
  import rx_pkg::*;
#(
  parameter logic [SYM_W-1:0] COMMA    = COMMA_DEF,
  parameter int               LOCK_CNT = 4,
  parameter int               MAX_GAP  = 16
) (
  input logic                   clk_32f,
  input logic                   reset_L,
  rx_serial_a_paralelo_if.slave bus
);

  logic [SYM_W-1:0] sym;
  logic             is_comma;

  rx_comma_detect #(.COMMA(COMMA)) u_comma_detect (
    .clk_32f     (clk_32f),
    .reset_L     (reset_L),
    .data_serial (bus.data_serial),
    .sym         (sym),
    .is_comma    (is_comma)
  );

  rx_state_e        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       comma_cnt_q, comma_cnt_d;
  logic [NIB_W-1:0] data_q, data_d;
  logic [NIB_W-1:0] lo_q, lo_d;
  logic             valid_q, valid_d;
  logic             stb_q, stb_d;
  logic             pend_q, pend_d;
  logic             boundary;

`ifdef RX_LOSS_OF_SYNC_EN
  localparam int GAP_W = $clog2(MAX_GAP + 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  assign boundary = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 3'd1;
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    lo_d        = lo_q;
    valid_d     = valid_q;
    stb_d       = 1'b0;
    pend_d      = pend_q;
`ifdef RX_LOSS_OF_SYNC_EN
    gap_d       = gap_q;
`endif
    case (state_q)
      SEARCH: begin
        // Hold the bit counter at 0 so the bit after a comma starts a fresh symbol.
        bit_cnt_d = 3'd0;
        if (is_comma) begin
          state_d     = COUNTING;
          comma_cnt_d = 4'd1;
        end
      end
      COUNTING: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if (comma_cnt_q + 4'd1 == 4'(LOCK_CNT)) begin
              state_d = LOCKED;
            end
          end else begin
            state_d     = SEARCH;
            comma_cnt_d = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          data_d  = sym[SYM_W-1:NIB_W];
          lo_d    = sym[NIB_W-1:0];
          valid_d = !is_comma;
          stb_d   = 1'b1;
          pend_d  = 1'b1;
`ifdef RX_LOSS_OF_SYNC_EN
          if (is_comma) begin
            gap_d = '0;
          end else if (gap_q + 1'b1 == GAP_W'(MAX_GAP)) begin
            state_d     = SEARCH;
            comma_cnt_d = 4'd0;
            data_d      = '0;
            valid_d     = 1'b0;
            stb_d       = 1'b0;
            pend_d      = 1'b0;
            gap_d       = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
`endif
        end else if (bit_cnt_q == 3'd3 && pend_q) begin
          // Low nibble goes out four edges after the boundary that loaded it.
          data_d = lo_q;
          stb_d  = 1'b1;
          pend_d = 1'b0;
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state_q     <= SEARCH;
      bit_cnt_q   <= 3'd0;
      comma_cnt_q <= 4'd0;
      data_q      <= '0;
      lo_q        <= '0;
      valid_q     <= 1'b0;
      stb_q       <= 1'b0;
      pend_q      <= 1'b0;
`ifdef RX_LOSS_OF_SYNC_EN
      gap_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      lo_q        <= lo_d;
      valid_q     <= valid_d;
      stb_q       <= stb_d;
      pend_q      <= pend_d;
`ifdef RX_LOSS_OF_SYNC_EN
      gap_q       <= gap_d;
`endif
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.nib_stb   = stb_q;
  assign bus.active    = (state_q == LOCKED);

endmodule

// File: tb/tb_rx_serial_a_paralelo.sv
// Directed bench for rx_serial_a_paralelo: expected nibbles are queued as symbols are sent
// and a monitor pops one on every nib_stb.
module tb_rx_serial_a_paralelo;

  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;

  rx_serial_a_paralelo_if bus ();

  rx_serial_a_paralelo dut (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk_32f = ~clk_32f;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_q[$];
  bit         locked_m = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Each symbol received while locked yields {valid, nibble} twice, high first.
  task automatic push_sym(input logic [7:0] b);
    exp_q.push_back({b != 8'hBC, b[7:4]});
    exp_q.push_back({b != 8'hBC, b[3:0]});
  endtask

  task automatic send_bit(input logic b);
    bus.data_serial = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (locked_m) push_sym(b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic do_reset();
    locked_m        = 1'b0;
    bus.data_serial = 1'b0;
    reset_L         = 1'b0;
    @(posedge clk_32f);
    #1;
    reset_L = 1'b1;
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    exp_q.delete();
  endtask

  // Three junk bits, then four commas; active must rise exactly on the 4th comma's last bit.
  task automatic lock_seq();
    logic [7:0] c;
    c = 8'hBC;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (3) send_byte(c);
    chk("active_after_3_commas", {7'd0, bus.active}, 8'd0);
    for (int i = 7; i >= 1; i--) send_bit(c[i]);
    chk("active_before_last_bit", {7'd0, bus.active}, 8'd0);
    send_bit(c[0]);
    chk("active_at_lock", {7'd0, bus.active}, 8'd1);
    chk("valid_at_lock", {7'd0, bus.valid_out}, 8'd0);
    chk("stb_at_lock", {7'd0, bus.nib_stb}, 8'd0);
    locked_m = 1'b1;
  endtask

  always @(negedge clk_32f) begin
    if (bus.nib_stb === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_nibble actual=%0h valid=%0b expected=none t=%0t",
                 bus.data_out, bus.valid_out, $time);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        chk("nibble", {3'd0, bus.valid_out, bus.data_out}, {3'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    c = 8'hBC;
    bus.data_serial = 1'b0;
    reset_L         = 1'b0;
    repeat (2) @(posedge clk_32f);
    #1;
    chk("reset_data", {4'd0, bus.data_out}, 8'd0);
    chk("reset_valid", {7'd0, bus.valid_out}, 8'd0);
    chk("reset_stb", {7'd0, bus.nib_stb}, 8'd0);
    chk("reset_active", {7'd0, bus.active}, 8'd0);
    reset_L = 1'b1;
    repeat (3) send_bit(1'b0);

    // Lock, then data symbol and a comma; latency checked directly as well as by the monitor.
    lock_seq();
    send_byte(8'h5A);
    chk("hi_5_data", {4'd0, bus.data_out}, 8'h05);
    chk("hi_5_stb", {7'd0, bus.nib_stb}, 8'd1);
    chk("hi_5_valid", {7'd0, bus.valid_out}, 8'd1);
    push_sym(c);
    for (int i = 7; i >= 4; i--) send_bit(c[i]);
    chk("lo_A_data", {4'd0, bus.data_out}, 8'h0A);
    chk("lo_A_stb", {7'd0, bus.nib_stb}, 8'd1);
    for (int i = 3; i >= 0; i--) send_bit(c[i]);
    chk("comma_hi_data", {4'd0, bus.data_out}, 8'h0B);
    chk("comma_hi_valid", {7'd0, bus.valid_out}, 8'd0);
    repeat (4) send_bit(1'b0);
    chk("comma_lo_data", {4'd0, bus.data_out}, 8'h0C);
    chk("comma_lo_valid", {7'd0, bus.valid_out}, 8'd0);
    do_reset();

    // Broken lock sequence, then a clean lock and back-to-back data.
    send_byte(c);
    send_byte(c);
    send_byte(8'h00);
    chk("broken_active", {7'd0, bus.active}, 8'd0);
    lock_seq();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(c);
    repeat (4) send_bit(1'b0);
    do_reset();

    // Reset between the nibbles of 8'h3C: low nibble must never appear.
    lock_seq();
    locked_m = 1'b0;
    exp_q.push_back(5'h13);
    send_byte(8'h3C);
    chk("mid_hi_data", {4'd0, bus.data_out}, 8'h03);
    send_bit(1'b0);
    reset_L = 1'b0;
    send_bit(1'b0);
    chk("mid_rst_data", {4'd0, bus.data_out}, 8'd0);
    chk("mid_rst_valid", {7'd0, bus.valid_out}, 8'd0);
    chk("mid_rst_stb", {7'd0, bus.nib_stb}, 8'd0);
    chk("mid_rst_active", {7'd0, bus.active}, 8'd0);
    reset_L = 1'b1;
    repeat (8) send_bit(1'b0);
    chk("mid_no_relock", {7'd0, bus.active}, 8'd0);
    lock_seq();
    do_reset();

    // Long run of data symbols while locked.
    lock_seq();
`ifdef RX_LOSS_OF_SYNC_EN
    repeat (15) send_byte(8'h5A);
    send_byte(c);
    chk("gap15_comma_active", {7'd0, bus.active}, 8'd1);
    repeat (15) send_byte(8'hA5);
    chk("gap15_active", {7'd0, bus.active}, 8'd1);
    locked_m = 1'b0;
    send_byte(8'hA5);
    chk("gap16_active", {7'd0, bus.active}, 8'd0);
    chk("gap16_data", {4'd0, bus.data_out}, 8'd0);
    chk("gap16_valid", {7'd0, bus.valid_out}, 8'd0);
    chk("gap16_stb", {7'd0, bus.nib_stb}, 8'd0);
    repeat (8) send_bit(1'b0);
`else
    repeat (16) send_byte(8'hA5);
    chk("hold_active", {7'd0, bus.active}, 8'd1);
    send_byte(c);
    repeat (4) send_bit(1'b0);
`endif
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
